// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU control sequencer: state encodings and default sizing.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'b000,
        StExec1  = 3'b001,
        StExec2  = 3'b010,
        StHalted = 3'b100,
        StFault  = 3'b101
    } seq_state_e;

    localparam int unsigned DefaultTimeout = 64;
    localparam int unsigned DefaultCntW    = 16;

endpackage

// File: rtl/seq_timeout_counter.sv
// Stall-cycle counter for the sequencer; flags expiry when TIMEOUT-1 stall cycles have elapsed.
module seq_timeout_counter #(
    parameter int unsigned Timeout = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CntW'(Timeout - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Registered control sequencer: FETCH/EXEC1/EXEC2 stepping with memory stall timeout,
// debug halt/resume/single-step, and a retired-instruction counter.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = DefaultCntW,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mem_ack_i,
    input  logic             mem_op_i,
    input  logic             extra_i,
    input  logic             p_i,
    input  logic             tf_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    input  logic             step_i,
    output logic             fetch_o,
    output logic             exec1_o,
    output logic             exec2_o,
    output logic             mem_req_o,
    output logic             instr_done_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    seq_state_e       state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic             step_pend_q, step_pend_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             stall;
    logic             retire;
    logic             tmo_expired;

    seq_timeout_counter #(
        .Timeout (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (!stall),
        .en_i      (stall),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        step_pend_d = step_pend_q;
        instr_cnt_d = instr_cnt_q;
        stall       = 1'b0;
        retire      = 1'b0;

        case (state_q)
            StFetch: begin
                if (mem_ack_i) begin
                    state_d = StExec1;
                end else begin
                    stall = 1'b1;
                end
            end
            StExec1: begin
                if (mem_op_i && !mem_ack_i) begin
                    stall = 1'b1;
                end else if (extra_i) begin
                    state_d = StExec2;
                end else if (p_i && !tf_i) begin
                    state_d = StExec1;
                end else begin
                    retire = 1'b1;
                end
            end
            StExec2: begin
                if (p_i) begin
                    state_d = StExec1;
                end else begin
                    retire = 1'b1;
                end
            end
            StHalted: begin
                if (halt_req_i) begin
                    state_d = StHalted;
                end else if (step_i) begin
                    state_d     = StFetch;
                    step_pend_d = 1'b1;
                end else if (resume_i) begin
                    state_d     = StFetch;
                    step_pend_d = 1'b0;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase

        if (stall && tmo_expired) begin
            state_d = StFault;
        end

        // A halt request is only remembered while running; it is honoured at the next retire.
        if (halt_req_i && (state_q == StFetch || state_q == StExec1 || state_q == StExec2)) begin
            halt_pend_d = 1'b1;
        end

        if (retire) begin
            state_d     = (halt_pend_q || step_pend_q || halt_req_i) ? StHalted : StFetch;
            halt_pend_d = 1'b0;
            step_pend_d = 1'b0;
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StFetch;
            halt_pend_q <= 1'b0;
            step_pend_q <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            step_pend_q <= step_pend_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign fetch_o      = (state_q == StFetch);
    assign exec1_o      = (state_q == StExec1);
    assign exec2_o      = (state_q == StExec2);
    assign halted_o     = (state_q == StHalted);
    assign fault_o      = (state_q == StFault);
    assign mem_req_o    = fetch_o || (exec1_o && mem_op_i);
    assign instr_done_o = retire;
    assign state_o      = state_q;
    assign instr_cnt_o  = instr_cnt_q;

endmodule
